// File: rtl/loader_pkg.sv
// Shared state encoding and frame constants for the serial program loader.
// Imported by the loader FSM and its byte packer.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         BYTE_W     = 8;
    localparam int         LEN_W      = 16;
    localparam int         WORD_W     = 32;
    localparam int         LANES      = 4;
    localparam int         LANE_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Enable mask with the n lowest lanes set.
    function automatic logic [LANES-1:0] lane_mask(
        input logic [LANE_CNT_W-1:0] n
    );
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(n)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words with byte enables.
// Unused lanes of a flushed tail word are forced to zero.
module byte_packer
    import loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_flush,
    input  logic [BYTE_W-1:0]       i_data,
    output logic [WORD_W-1:0]       o_wdata,
    output logic [LANES-1:0]        o_be
);

    logic [LANES-1:0][BYTE_W-1:0] r_lane;
    logic [1:0]                   r_cnt;
    logic [WORD_W-1:0]            r_wdata;
    logic [LANES-1:0]             r_be;

    logic [LANES-1:0][BYTE_W-1:0] w_word;
    logic [LANES-1:0]             w_be;

    // Word as it looks with the incoming byte already placed.
    always_comb begin
        w_word        = r_lane;
        w_word[r_cnt] = i_data;
        w_be          = lane_mask({1'b0, r_cnt} + 3'd1);
        for (int i = 0; i < LANES; i++) begin
            if (!w_be[i]) begin
                w_word[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lane  <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_cnt  <= '0;
        end else if (i_push) begin
            if (i_flush) begin
                r_wdata <= w_word;
                r_be    <= w_be;
                r_lane  <= '0;
                r_cnt   <= '0;
            end else begin
                r_lane[r_cnt] <= i_data;
                r_cnt         <= r_cnt + 2'd1;
            end
        end
    end

    assign o_wdata = r_wdata;
    assign o_be    = r_be;

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: parses A5/len/data/checksum frames into word writes
// to instruction memory while holding the CPU in reset.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_BYTES = 4096
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    output logic [LANES-1:0]     mem_be,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [LEN_W:0]    MAX_LEN = (LEN_W+1)'(MAX_BYTES);

    state_t r_state;
    state_t w_next;

    logic [BYTE_W-1:0] r_len_lo;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [BYTE_W-1:0] r_sum;
    logic [ADDR_W-1:0] r_widx;

    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_err;

    logic              w_xfer;
    logic              w_sync;
    logic [LEN_W-1:0]  w_len;
    logic              w_too_long;
    logic              w_last;
    logic              w_push;
    logic              w_flush;
    logic [BYTE_W-1:0] w_sum_next;

    assign w_xfer     = in_valid & r_in_ready;
    assign w_sync     = (r_state == IDLE) && w_xfer && (in_data == SYNC_BYTE);
    assign w_len      = {in_data, r_len_lo};
    assign w_too_long = {1'b0, w_len} > MAX_LEN;
    assign w_last     = (r_cnt + 16'd1) == r_len;
    assign w_push     = (r_state == DATA) && w_xfer;
    assign w_flush    = w_push && ((r_cnt[1:0] == 2'd3) || w_last);
    assign w_sum_next = r_sum + in_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_next = LEN0;
                end
            end
            LEN0: begin
                if (w_xfer) begin
                    w_next = LEN1;
                end
            end
            LEN1: begin
                if (w_xfer) begin
                    if (w_too_long) begin
                        w_next = ERR;
                    end else if (w_len == '0) begin
                        w_next = CSUM;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_flush) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                w_next = (r_cnt == r_len) ? CSUM : DATA;
            end
            CSUM: begin
                if (w_xfer) begin
                    w_next = (w_sum_next == 8'h00) ? DONE : ERR;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            ERR: begin
                w_next = ERR;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Frame counters and running checksum; the sync byte is not summed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len_lo <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_widx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sync) begin
                        r_len  <= '0;
                        r_cnt  <= '0;
                        r_sum  <= '0;
                        r_widx <= '0;
                    end
                end
                LEN0: begin
                    if (w_xfer) begin
                        r_len_lo <= in_data;
                        r_sum    <= w_sum_next;
                    end
                end
                LEN1: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        r_sum <= w_sum_next;
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 16'd1;
                        r_sum <= w_sum_next;
                    end
                end
                WRITE: begin
                    r_widx <= r_widx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == IDLE) || (w_next == LEN0) ||
                           (w_next == LEN1) || (w_next == DATA) ||
                           (w_next == CSUM);
            r_mem_we    <= (w_next == WRITE);
            r_load_done <= (w_next == DONE);
            if (w_next == WRITE) begin
                r_mem_addr <= BASE + r_widx;
            end
            if (w_next == ERR) begin
                r_load_err <= 1'b1;
            end
            if ((w_next == LEN0) || (w_next == ERR)) begin
                r_cpu_hold <= 1'b1;
            end else if (r_state == DONE) begin
                r_cpu_hold <= 1'b0;
            end
        end
    end

    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_sync),
        .i_push  (w_push),
        .i_flush (w_flush),
        .i_data  (in_data),
        .o_wdata (mem_wdata),
        .o_be    (mem_be)
    );

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign cpu_hold  = r_cpu_hold;
    assign load_done = r_load_done;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good frames, tails, empty and
// oversize frames, bad checksum and a mid-frame reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          wr_n   = 0;
    int          done_n = 0;
    logic [15:0] wa [64];
    logic [31:0] wd [64];
    logic [3:0]  wb [64];

    // Write/done log, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_we) begin
            if (wr_n < 64) begin
                wa[wr_n] = mem_addr;
                wd[wr_n] = mem_wdata;
                wb[wr_n] = mem_be;
            end
            wr_n++;
        end
        if (load_done) begin
            done_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d[$], input logic [7:0] cs_off,
                              input int gmax);
        logic [7:0]  s;
        logic [15:0] len;
        len = 16'(d.size());
        s   = len[7:0] + len[15:8];
        send(8'hA5, int'($urandom_range(gmax)));
        send(len[7:0], int'($urandom_range(gmax)));
        send(len[15:8], int'($urandom_range(gmax)));
        foreach (d[i]) begin
            send(d[i], int'($urandom_range(gmax)));
            s = s + d[i];
        end
        send(8'(8'h00 - s) + cs_off, int'($urandom_range(gmax)));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
        chk({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_err"},  32'(load_err),  32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] fa[$];
        logic [7:0] fb[$];
        logic [7:0] fz[$];
        int w0;
        int d0;
        fa = '{8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'h90, 8'h90, 8'hC3};
        fb = '{8'h55, 8'h89, 8'hE5, 8'h83, 8'hEC};
        fz = {};

        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        // Eight-byte frame, two full words.
        w0 = wr_n; d0 = done_n;
        send_frame(fa, 8'h00, 0);
        chk("a_done_pulse", 32'(load_done), 32'd1);
        @(negedge clk);
        chk("a_done_low", 32'(load_done), 32'd0);
        chk("a_hold_low", 32'(cpu_hold), 32'd0);
        chk("a_nwr", 32'(wr_n - w0), 32'd2);
        chk("a_w0_addr", 32'(wa[w0]), 32'd0);
        chk("a_w0_data", wd[w0], 32'h000001B8);
        chk("a_w0_be", 32'(wb[w0]), 32'hF);
        chk("a_w1_addr", 32'(wa[w0+1]), 32'd1);
        chk("a_w1_data", wd[w0+1], 32'hC3909000);
        chk("a_w1_be", 32'(wb[w0+1]), 32'hF);
        chk("a_ndone", 32'(done_n - d0), 32'd1);
        chk("a_err", 32'(load_err), 32'd0);

        // Five bytes: one full word plus a 1-byte tail.
        w0 = wr_n; d0 = done_n;
        send_frame(fb, 8'h00, 0);
        repeat (2) @(negedge clk);
        chk("b_nwr", 32'(wr_n - w0), 32'd2);
        chk("b_w0_data", wd[w0], 32'h83E58955);
        chk("b_w0_be", 32'(wb[w0]), 32'hF);
        chk("b_w1_addr", 32'(wa[w0+1]), 32'd1);
        chk("b_w1_data", wd[w0+1], 32'h000000EC);
        chk("b_w1_be", 32'(wb[w0+1]), 32'h1);
        chk("b_ndone", 32'(done_n - d0), 32'd1);

        // Empty program.
        w0 = wr_n; d0 = done_n;
        send_frame(fz, 8'h00, 0);
        repeat (2) @(negedge clk);
        chk("z_nwr", 32'(wr_n - w0), 32'd0);
        chk("z_ndone", 32'(done_n - d0), 32'd1);
        chk("z_hold", 32'(cpu_hold), 32'd0);

        // Checksum off by one.
        w0 = wr_n; d0 = done_n;
        send_frame(fa, 8'h01, 0);
        repeat (2) @(negedge clk);
        chk("cs_err", 32'(load_err), 32'd1);
        chk("cs_hold", 32'(cpu_hold), 32'd1);
        chk("cs_ready", 32'(in_ready), 32'd0);
        chk("cs_ndone", 32'(done_n - d0), 32'd0);
        repeat (6) @(negedge clk);
        chk("cs_err_sticky", 32'(load_err), 32'd1);
        chk("cs_ready_stuck", 32'(in_ready), 32'd0);
        do_reset();
        chk("cs_err_cleared", 32'(load_err), 32'd0);

        // Oversize length 0x2000.
        w0 = wr_n;
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h20, 0);
        chk("big_err", 32'(load_err), 32'd1);
        chk("big_ready", 32'(in_ready), 32'd0);
        chk("big_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);
        chk("big_nwr", 32'(wr_n - w0), 32'd0);
        do_reset();

        // Garbage, gaps, then reset after the sixth data byte.
        w0 = wr_n; d0 = done_n;
        send(8'h00, 1);
        send(8'hFF, 2);
        send(8'hA5, 1);
        send(8'h08, 2);
        send(8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            send(fa[i], int'($urandom_range(2)));
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("mid");
        chk("mid_nwr", 32'(wr_n - w0), 32'd1);
        chk("mid_w0_data", wd[w0], 32'h000001B8);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_nwr_after", 32'(wr_n - w0), 32'd1);

        w0 = wr_n;
        send_frame(fb, 8'h00, 2);
        repeat (2) @(negedge clk);
        chk("r_nwr", 32'(wr_n - w0), 32'd2);
        chk("r_w0_addr", 32'(wa[w0]), 32'd0);
        chk("r_w0_data", wd[w0], 32'h83E58955);
        chk("r_w1_data", wd[w0+1], 32'h000000EC);
        chk("r_w1_be", 32'(wb[w0+1]), 32'h1);
        chk("r_ndone", 32'(done_n - d0), 32'd1);
        chk("r_hold", 32'(cpu_hold), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
